// File: rtl/countdown_counter_pkg.sv
// Shared stopwatch definitions: countdown state encoding, digit width and
// the digit clamp used by every counter load path.
package countdown_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } cd_state_e;

  // Digits that cannot exist in the chosen radix saturate to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] digit,
                                                     input int base);
    logic [DIGIT_W:0] base_w;
    logic [DIGIT_W:0] max_w;
    base_w = (DIGIT_W+1)'(base);
    max_w  = base_w - 5'd1;
    if ({1'b0, digit} >= base_w) begin
      return max_w[DIGIT_W-1:0];
    end else begin
      return digit;
    end
  endfunction

endpackage

// File: rtl/countdown_counter_bcd_down_digit.sv
// One digit of the countdown borrow chain: subtracts borrow_in and wraps
// 0 to BASE-1, raising borrow_out when it wraps.
module bcd_down_digit
  import countdown_counter_pkg::*;
#(
  parameter int BASE = 10
) (
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(BASE - 1);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = MAX_DIGIT;
        borrow_out = 1'b1;
      end else begin
        digit_out  = digit_in - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      digit_out  = digit_in;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_counter.sv
// Multi-digit base-BASE down-counter with preset load, zero detection and
// optional auto-reload; all outputs come straight from flops.
module countdown_counter
  import countdown_counter_pkg::*;
#(
  parameter int BASE             = 10,
  parameter int NUMBER_OF_NYBLES = 1,
  parameter int AUTO_RELOAD      = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic                                  enable,
  input  logic [DIGIT_W*NUMBER_OF_NYBLES-1:0]   numberIn,
  output logic [DIGIT_W*NUMBER_OF_NYBLES-1:0]   numberOut,
  output logic                                  threshold,
  output logic                                  done
);

  localparam int W = DIGIT_W * NUMBER_OF_NYBLES;

  logic [W-1:0]              count_q, count_d;
  logic [W-1:0]              preset_q, preset_d;
  cd_state_e                 state_q, state_d;
  logic                      threshold_q, threshold_d;
  logic                      done_q, done_d;
  logic [W-1:0]              clamped_s;
  logic [W-1:0]              dec_s;
  logic [NUMBER_OF_NYBLES:0] borrow_s;

  assign borrow_s[0] = 1'b1;

  for (genvar i = 0; i < NUMBER_OF_NYBLES; i++) begin : g_digit
    bcd_down_digit #(.BASE(BASE)) u_digit (
      .digit_in   (count_q[i*DIGIT_W +: DIGIT_W]),
      .borrow_in  (borrow_s[i]),
      .digit_out  (dec_s[i*DIGIT_W +: DIGIT_W]),
      .borrow_out (borrow_s[i+1])
    );
    assign clamped_s[i*DIGIT_W +: DIGIT_W] = clamp_digit(numberIn[i*DIGIT_W +: DIGIT_W], BASE);
  end

  // A borrow out of the top digit means the count was already zero, so it is never taken.
  always_comb begin
    count_d     = count_q;
    preset_d    = preset_q;
    state_d     = state_q;
    threshold_d = 1'b0;
    if (load) begin
      preset_d = clamped_s;
      count_d  = clamped_s;
      state_d  = (clamped_s != '0) ? ST_RUN : ST_EXPIRED;
    end else if (enable) begin
      case (state_q)
        ST_RUN: begin
          if (borrow_s[NUMBER_OF_NYBLES]) begin
            state_d = ST_EXPIRED;
          end else if (dec_s == '0) begin
            count_d     = dec_s;
            threshold_d = 1'b1;
            state_d     = ST_EXPIRED;
          end else begin
            count_d = dec_s;
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if ((AUTO_RELOAD != 32'sd0) && (preset_q != '0)) begin
            count_d = preset_q;
            state_d = ST_RUN;
          end else begin
            count_d = '0;
            state_d = ST_EXPIRED;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    done_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      preset_q    <= '0;
      state_q     <= ST_IDLE;
      threshold_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      preset_q    <= preset_d;
      state_q     <= state_d;
      threshold_q <= threshold_d;
      done_q      <= done_d;
    end
  end

  assign numberOut = count_q;
  assign threshold = threshold_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_counter.sv
// Directed bench for countdown_counter across four parameter sets.
module tb_countdown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: BASE10 N2 no reload, B: BASE10 N2 reload, C: BASE16 N3, D: BASE6 N1
  logic        a_load = 1'b0, a_en = 1'b0, a_thr, a_done;
  logic [7:0]  a_in = 8'h00, a_out;
  logic        b_load = 1'b0, b_en = 1'b0, b_thr, b_done;
  logic [7:0]  b_in = 8'h00, b_out;
  logic        c_load = 1'b0, c_en = 1'b0, c_thr, c_done;
  logic [11:0] c_in = 12'h000, c_out;
  logic        d_load = 1'b0, d_en = 1'b0, d_thr, d_done;
  logic [3:0]  d_in = 4'h0, d_out;

  countdown_counter #(.BASE(10), .NUMBER_OF_NYBLES(2), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst(rst), .load(a_load), .enable(a_en), .numberIn(a_in),
    .numberOut(a_out), .threshold(a_thr), .done(a_done));
  countdown_counter #(.BASE(10), .NUMBER_OF_NYBLES(2), .AUTO_RELOAD(1)) dut_b (
    .clk(clk), .rst(rst), .load(b_load), .enable(b_en), .numberIn(b_in),
    .numberOut(b_out), .threshold(b_thr), .done(b_done));
  countdown_counter #(.BASE(16), .NUMBER_OF_NYBLES(3), .AUTO_RELOAD(0)) dut_c (
    .clk(clk), .rst(rst), .load(c_load), .enable(c_en), .numberIn(c_in),
    .numberOut(c_out), .threshold(c_thr), .done(c_done));
  countdown_counter #(.BASE(6), .NUMBER_OF_NYBLES(1), .AUTO_RELOAD(0)) dut_d (
    .clk(clk), .rst(rst), .load(d_load), .enable(d_en), .numberIn(d_in),
    .numberOut(d_out), .threshold(d_thr), .done(d_done));

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] din;
    logic [7:0] q;
    logic       thr;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  logic [7:0] b_exp_q[8]   = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
  logic       b_exp_thr[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // Table for dut A
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0});
    for (int v = 11; v >= 0; v--)
      vecs.push_back('{1'b0, 1'b1, 8'h00, bcd2(v), (v == 0), (v == 0)});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'h45, 8'h45, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'hA7, 8'h97, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h99, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});

    #12 rst = 1'b1;
    #1;
    chk("reset a_out", 32'(a_out), 32'h0);
    chk("reset a_done", 32'(a_done), 32'h0);
    chk("reset a_thr", 32'(a_thr), 32'h0);

    foreach (vecs[i]) begin
      a_load = vecs[i].ld;
      a_en   = vecs[i].en;
      a_in   = vecs[i].din;
      tick();
      chk($sformatf("vec%0d q", i), 32'(a_out), 32'(vecs[i].q));
      chk($sformatf("vec%0d thr", i), 32'(a_thr), 32'(vecs[i].thr));
      chk($sformatf("vec%0d done", i), 32'(a_done), 32'(vecs[i].dn));
    end
    a_load = 1'b0; a_en = 1'b0;

    // Auto-reload period is preset+1 enables
    b_load = 1'b1; b_in = 8'h03;
    tick();
    chk("b load 03", 32'(b_out), 32'h03);
    b_load = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("b reload%0d q", k), 32'(b_out), 32'(b_exp_q[k]));
      chk($sformatf("b reload%0d thr", k), 32'(b_thr), 32'(b_exp_thr[k]));
    end
    b_en = 1'b0; b_load = 1'b1; b_in = 8'h01;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    tick();
    chk("b p1 q0", 32'(b_out), 32'h00);
    chk("b p1 thr0", 32'(b_thr), 32'h1);
    tick();
    chk("b p1 q1", 32'(b_out), 32'h01);
    chk("b p1 thr1", 32'(b_thr), 32'h0);
    tick();
    chk("b p1 thr2", 32'(b_thr), 32'h1);
    b_en = 1'b0; b_load = 1'b1; b_in = 8'h00;
    tick();
    chk("b load0 done", 32'(b_done), 32'h1);
    chk("b load0 thr", 32'(b_thr), 32'h0);
    b_load = 1'b0; b_en = 1'b1;
    tick();
    chk("b zero preset q", 32'(b_out), 32'h00);
    chk("b zero preset thr", 32'(b_thr), 32'h0);
    chk("b zero preset done", 32'(b_done), 32'h1);
    b_en = 1'b0;

    // Hex, three digits: full borrow chain
    c_load = 1'b1; c_in = 12'h100;
    tick();
    chk("c load", 32'(c_out), 32'h100);
    c_load = 1'b0; c_en = 1'b1;
    tick();
    chk("c borrow q", 32'(c_out), 32'h0FF);
    chk("c borrow thr", 32'(c_thr), 32'h0);
    chk("c borrow done", 32'(c_done), 32'h0);
    c_en = 1'b0; c_load = 1'b1; c_in = 12'hFFF;
    tick();
    chk("c no clamp", 32'(c_out), 32'hFFF);
    c_in = 12'h001;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    tick();
    chk("c zero q", 32'(c_out), 32'h000);
    chk("c zero thr", 32'(c_thr), 32'h1);
    c_en = 1'b0;

    // Base 6, single digit
    d_load = 1'b1; d_in = 4'h5;
    tick();
    d_load = 1'b0; d_en = 1'b1;
    for (int v = 4; v >= 0; v--) begin
      tick();
      chk($sformatf("d step%0d q", v), 32'(d_out), 32'(v));
      chk($sformatf("d step%0d thr", v), 32'(d_thr), 32'(v == 0));
    end
    d_en = 1'b0; d_load = 1'b1; d_in = 4'h9;
    tick();
    chk("d clamp", 32'(d_out), 32'h5);
    d_load = 1'b0;

    // Asynchronous reset mid-count
    a_load = 1'b1; a_in = 8'h37;
    b_load = 1'b1; b_in = 8'h01;
    tick();
    chk("a pre-reset", 32'(a_out), 32'h37);
    a_load = 1'b0; b_load = 1'b0; b_en = 1'b1;
    tick();
    chk("b pre-reset thr", 32'(b_thr), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async a_out", 32'(a_out), 32'h00);
    chk("async a_done", 32'(a_done), 32'h0);
    chk("async b_thr", 32'(b_thr), 32'h0);
    chk("async b_done", 32'(b_done), 32'h0);
    b_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a_en = 1'b1;
    tick();
    chk("idle a_out", 32'(a_out), 32'h00);
    chk("idle a_done", 32'(a_done), 32'h0);
    tick();
    chk("idle a_thr", 32'(a_thr), 32'h0);
    chk("idle a_done2", 32'(a_done), 32'h0);
    a_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_counter.md
# countdown_counter

Preset-and-decrement companion to the stopwatch's up-counter: a multi-digit base-BASE down-counter for timer/countdown mode. A value is loaded on numberIn, the count decrements once per enable pulse from the shared tick prescaler, and completion is flagged on reaching zero. numberOut feeds the same display path as the up-counter.

## Interface
- BASE, 10, digit radix (2..16); every digit wraps 0 -> BASE-1 on borrow
- NUMBER_OF_NYBLES, 1, number of 4-bit digits in the count
- AUTO_RELOAD, 0, 1 = an enable while expired reloads the stored preset; 0 = hold at zero

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  capture numberIn as the preset and the current count
- enable  in  1  single-cycle decrement request (tick)
- numberIn  in  4*NUMBER_OF_NYBLES  preset value, one digit per nybble, LS digit in [3:0]
- numberOut  out  4*NUMBER_OF_NYBLES  current count, registered
- threshold  out  1  one-cycle pulse in the cycle numberOut first becomes zero through decrement
- done  out  1  level: high while state is EXPIRED

## Operation
- States: IDLE (after reset, never loaded), RUN (count nonzero), EXPIRED (count zero after load or countdown).
- Reset (rst low, asynchronous): numberOut = 0, preset register = 0, threshold = 0, done = 0, state = IDLE. Takes effect immediately, including mid-count. Release is synchronous to clk.
- load has priority over enable in every state.
  - Each input digit >= BASE is clamped to BASE-1.
  - The clamped value goes to both the preset register and the count.
  - Next state is RUN if the clamped value is nonzero, else EXPIRED.
  - A load never pulses threshold. Loading zero sets done without a pulse.
- enable in IDLE: ignored.
- enable in RUN: decrement by 1 using a digit-serial borrow chain within the same cycle.
  - Digit 0 borrows to BASE-1 and propagates the borrow upward.
  - If the result is zero: threshold = 1 for that cycle, and the state becomes EXPIRED.
- enable in EXPIRED:
  - AUTO_RELOAD = 0: count holds at 0, no threshold.
  - AUTO_RELOAD = 1: count = preset and state = RUN; if the preset is zero, the block stays EXPIRED with no pulse.
  - The period is therefore preset+1 enables.
- enable low: count, state and preset hold; threshold = 0.
- Decrement never underflows; zero is only left via load or reload.

## Timing
- All outputs are registered.
- numberOut, done and threshold reflect a load or enable sampled at edge N, visible after edge N.
- Latency is one cycle. No combinational path from any input to any output.
- threshold is never high for two consecutive cycles, even with enable held high.
- enable may be held high continuously; it is treated as one decrement per cycle.

## Structure
- The shared stopwatch package holds:
  - the state enum (IDLE, RUN, EXPIRED), 2-bit encoding
  - the digit width constant 4
  - a digit-clamp function, reused by the up-counter's load path
- One sub-module, bcd_down_digit:
  - combinational single-digit decrement with borrow_in, borrow_out and a BASE parameter
  - instantiated NUMBER_OF_NYBLES times via generate
- The state register and preset register live in the top level.

## Test plan
- Reset: drive rst low mid-count with count at 0x37 -> numberOut = 0x00, done = 0 and threshold = 0 immediately, before the next clk edge; enables after release are ignored (IDLE).
- BASE=10, N=2, load 0x12, then 12 single enables -> count sequence 0x11, 0x10, 0x09 (borrow), ..., 0x01, 0x00; threshold high exactly on the cycle numberOut = 0x00; done stays high after.
- AUTO_RELOAD=0, enable held 5 cycles after expiry -> numberOut stays 0x00, threshold stays 0, done = 1. AUTO_RELOAD=1, load 0x03, enable held 8 cycles -> 0x02, 0x01, 0x00 (pulse), 0x03, 0x02, 0x01, 0x00 (pulse), 0x03.
- load and enable in the same cycle with numberIn = 0x45 -> numberOut = 0x45, not 0x44. Load 0x00 -> done = 1 with no threshold pulse. Load 0xA7 with BASE=10 -> numberOut = 0x97.
- BASE=16, N=3, load 0x100, one enable -> numberOut = 0x0FF, threshold = 0. BASE=6, N=1, load 0x5, 5 enables -> 4, 3, 2, 1, 0 with a pulse at 0.
